// File: rtl/bin2bcd_seq.sv
// Sequential shift-and-add-3 binary-to-BCD converter, one binary bit per clock.
// Optional saturation to all-9s with an overflow flag: define BIN2BCD_SAT_EN.
module bin2bcd_seq #(
    parameter int unsigned BIN_W  = 8,
    parameter int unsigned DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  ovf
);

    localparam int unsigned BCD_W = 4 * DIGITS;
    localparam int unsigned SR_W  = BCD_W + BIN_W;
    localparam int unsigned CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BIN_W - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [SR_W-1:0]   sr;
    logic [SR_W-1:0]   sr_adj_c;
    logic [SR_W-1:0]   sr_shift_c;
    logic [CNT_W-1:0]  cnt;
    logic              accept_c;
    logic              last_c;
    logic              sat_c;

    // One double-dabble step: correct every digit field, then shift left.
    always_comb begin
        sr_adj_c = sr;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (sr[BIN_W + 4*i +: 4] >= 4'd5) begin
                sr_adj_c[BIN_W + 4*i +: 4] = sr[BIN_W + 4*i +: 4] + 4'd3;
            end
        end
        sr_shift_c = {sr_adj_c[SR_W-2:0], 1'b0};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        accept_c   = 1'b0;
        last_c     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept_c   = 1'b1;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt == LAST) begin
                    last_c     = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath and registered outputs; the last shift edge is also the DONE entry edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy    <= 1'b0;
            done    <= 1'b0;
            bcd_out <= '0;
            sr      <= '0;
            cnt     <= '0;
        end else begin
            busy <= (state_next != IDLE);
            done <= (state_next == DONE);
            if (accept_c) begin
                sr  <= {BCD_W'(0), bin_in};
                cnt <= '0;
            end else if (state == SHIFT) begin
                sr  <= sr_shift_c;
                cnt <= cnt + CNT_W'(1);
            end
            if (last_c) begin
                bcd_out <= sat_c ? {DIGITS{4'h9}} : sr_shift_c[SR_W-1:BIN_W];
            end
        end
    end

`ifdef BIN2BCD_SAT_EN
    localparam int unsigned P_W = BIN_W + 4;

    // Largest representable value, capped just above the binary range.
    function automatic logic [P_W-1:0] sat_limit();
        logic [P_W-1:0] p;
        p = P_W'(1);
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (p <= (P_W'(1) << BIN_W)) begin
                p = p * P_W'(10);
            end
        end
        return p - P_W'(1);
    endfunction

    localparam logic [P_W-1:0] LIMIT = sat_limit();

    logic sat_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_q <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            if (accept_c) begin
                sat_q <= (P_W'(bin_in) > LIMIT);
            end
            if (last_c) begin
                ovf <= sat_q;
            end
        end
    end

    assign sat_c = sat_q;
`else
    assign sat_c = 1'b0;
    assign ovf   = 1'b0;
`endif

endmodule
